// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: after init, grants the pin bus to refresh, the write sequencer
// or the read sequencer, and generates the periodic PRECHARGE-ALL + AUTO REFRESH itself.
module sdram_arbiter #(
  parameter int REF_PERIOD  = 1560,
  parameter int TRP         = 2,
  parameter int TRFC        = 7,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        S_CLK,
  input  logic        RST_N,
  input  logic        init_done,
  input  logic [4:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        wr_ack,
  input  logic [4:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        rd_ack,
  input  logic [4:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  output logic [4:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic        ref_overrun,
  output logic        timeout_err
);

  localparam logic [4:0]  CMD_NOP  = 5'b10111;
  localparam logic [4:0]  CMD_PREC = 5'b10010;
  localparam logic [4:0]  CMD_AREF = 5'b10001;
  localparam logic [11:0] ADDR_ALL = 12'h400;

  localparam int RW = (REF_PERIOD  > 1) ? $clog2(REF_PERIOD)  : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int SW = $clog2(TRP + TRFC + 2);

  localparam logic [RW-1:0] REF_LAST  = RW'(REF_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [SW-1:0] STEP_AREF = SW'(TRP + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(TRP + TRFC + 1);

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_READ, ST_AREF} state_t;

  state_t        state_q, state_d;
  logic          wr_en_q, wr_en_d;
  logic          rd_en_q, rd_en_d;
  logic          aref_req_q, aref_req_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [SW-1:0] aref_step_q, aref_step_d;
  logic [4:0]    aref_cmd_q, aref_cmd_d;
  logic [11:0]   aref_addr_q, aref_addr_d;
  logic          ref_overrun_q, ref_overrun_d;
  logic          timeout_err_q, timeout_err_d;
  logic          ref_expire;

  always_comb begin
    state_d       = state_q;
    wr_en_d       = 1'b0;
    rd_en_d       = 1'b0;
    to_cnt_d      = '0;
    aref_step_d   = '0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_INIT:  if (init_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (aref_req_q) begin
          state_d = ST_AREF;
        end else if (wr_req) begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
        end else if (rd_req) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
        end
      end
      ST_WRITE, ST_READ: begin
        if ((state_q == ST_WRITE) ? wr_ack : rd_ack) begin
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_AREF: begin
        if (aref_step_q == STEP_LAST) state_d = ST_IDLE;
        else                          aref_step_d = aref_step_q + 1'b1;
      end
      default:  state_d = ST_INIT;
    endcase
  end

  // Refresh timer runs in every state but INIT; a new expiry beats the clear on AREF entry.
  always_comb begin
    ref_cnt_d     = '0;
    ref_expire    = 1'b0;
    ref_overrun_d = ref_overrun_q;
    aref_req_d    = aref_req_q;
    if (state_q != ST_INIT) begin
      if (ref_cnt_q == REF_LAST) begin
        ref_expire = 1'b1;
        if (aref_req_q) ref_overrun_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 1'b1;
      end
    end
    if (ref_expire)                                    aref_req_d = 1'b1;
    else if (state_d == ST_AREF && state_q != ST_AREF) aref_req_d = 1'b0;
  end

  always_comb begin
    aref_cmd_d  = CMD_NOP;
    aref_addr_d = ADDR_ALL;
    if (state_d == ST_AREF) begin
      if (state_q != ST_AREF)          aref_cmd_d = CMD_PREC;
      else if (aref_step_d == STEP_AREF) aref_cmd_d = CMD_AREF;
    end
  end

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_INIT;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      aref_req_q    <= 1'b0;
      ref_cnt_q     <= '0;
      to_cnt_q      <= '0;
      aref_step_q   <= '0;
      aref_cmd_q    <= CMD_NOP;
      aref_addr_q   <= ADDR_ALL;
      ref_overrun_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      aref_req_q    <= aref_req_d;
      ref_cnt_q     <= ref_cnt_d;
      to_cnt_q      <= to_cnt_d;
      aref_step_q   <= aref_step_d;
      aref_cmd_q    <= aref_cmd_d;
      aref_addr_q   <= aref_addr_d;
      ref_overrun_q <= ref_overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    sdram_cmd  = init_cmd;
    sdram_addr = init_addr;
    case (state_q)
      ST_IDLE:  begin sdram_cmd = CMD_NOP;    sdram_addr = ADDR_ALL;    end
      ST_WRITE: begin sdram_cmd = wr_cmd;     sdram_addr = wr_addr;     end
      ST_READ:  begin sdram_cmd = rd_cmd;     sdram_addr = rd_addr;     end
      ST_AREF:  begin sdram_cmd = aref_cmd_q; sdram_addr = aref_addr_q; end
      default:  begin sdram_cmd = init_cmd;   sdram_addr = init_addr;   end
    endcase
  end

  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign ref_overrun = ref_overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
